alu_sequencer: RTL and testbench

- Requester-side controller for the combinational ALU.
- Accepts an operation request (two operands plus a 4-bit control code) over a valid/ready handshake and drives the ALU operand and control inputs.
- Waits a programmable settle time, then captures the ALU result and zero/neg flags.
- Presents the captured response on a second valid/ready handshake to the downstream datapath.

---
 rtl/alu_sequencer.sv | 159 +++++++++++++++
 tb/tb_alu_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: requester-side controller for a combinational ALU.
// Accepts an operation over a valid/ready handshake and drives the ALU inputs.
// After EXEC_CYCLES cycles it captures the result and flags, then offers them
// downstream on a second valid/ready handshake.
module alu_sequencer #(
  parameter int DATA_W      = 32,
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [DATA_W-1:0] i_req_op1,
  input  logic [DATA_W-1:0] i_req_op2,
  input  logic [3:0]        i_req_ctl,
  output logic [DATA_W-1:0] o_alu_operand1,
  output logic [DATA_W-1:0] o_alu_operand2,
  output logic [3:0]        o_alu_control,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_alu_zero,
  input  logic              i_alu_neg,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_result,
  output logic              o_rsp_zero,
  output logic              o_rsp_neg,
  output logic              o_rsp_err,
  output logic [CNT_W-1:0]  o_op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // The counter is loaded with EXEC_CYCLES-1 so the capture happens on the
  // EXEC_CYCLES-th edge after acceptance.
  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] alu_op1_q, alu_op1_d;
  logic [DATA_W-1:0] alu_op2_q, alu_op2_d;
  logic [3:0]        alu_ctl_q, alu_ctl_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_neg_q, rsp_neg_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  function automatic logic ctl_is_legal(input logic [3:0] ctl);
    case (ctl)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0110, 4'b1000, 4'b1001, 4'b1010: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Next-state and next-output computation for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    alu_ctl_d    = alu_ctl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_neg_d    = rsp_neg_q;
    rsp_err_d    = rsp_err_q;
    op_count_d   = op_count_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          if (ctl_is_legal(i_req_ctl)) begin
            alu_op1_d = i_req_op1;
            alu_op2_d = i_req_op2;
            alu_ctl_d = i_req_ctl;
            cnt_d     = EXEC_LOAD;
            state_d   = EXEC;
          end else begin
            rsp_result_d = '0;
            rsp_zero_d   = 1'b0;
            rsp_neg_d    = 1'b0;
            rsp_err_d    = 1'b1;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          rsp_result_d = i_alu_result;
          rsp_zero_d   = i_alu_zero;
          rsp_neg_d    = i_alu_neg;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          if (!rsp_err_q) begin
            op_count_d = op_count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register all state; reset drops any in-flight transaction.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      alu_ctl_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_neg_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      alu_ctl_q    <= alu_ctl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_neg_q    <= rsp_neg_d;
      rsp_err_q    <= rsp_err_d;
      op_count_q   <= op_count_d;
    end
  end

  assign o_req_ready    = (state_q == IDLE);
  assign o_alu_operand1 = alu_op1_q;
  assign o_alu_operand2 = alu_op2_q;
  assign o_alu_control  = alu_ctl_q;
  assign o_rsp_valid    = rsp_valid_q;
  assign o_rsp_result   = rsp_result_q;
  assign o_rsp_zero     = rsp_zero_q;
  assign o_rsp_neg      = rsp_neg_q;
  assign o_rsp_err      = rsp_err_q;
  assign o_op_count     = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: two sequencer instances (slow EXEC_CYCLES=3 with a 2-bit
// counter, fast EXEC_CYCLES=1 with a 16-bit counter), each wired to its own
// behavioural ALU. Shared request/response stimulus is steered to one
// instance at a time by 'sel'.
module tb_alu_sequencer;

  localparam int EXEC_A = 3;
  localparam int CNTW_A = 2;
  localparam int EXEC_B = 1;
  localparam int CNTW_B = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_op1 = '0;
  logic [31:0] req_op2 = '0;
  logic [3:0]  req_ctl = '0;
  logic        rsp_ready = 1'b0;

  // Instance A signals
  logic        req_ready_a, rsp_valid_a, rsp_zero_a, rsp_neg_a, rsp_err_a;
  logic        alu_zero_a, alu_neg_a;
  logic [31:0] alu_op1_a, alu_op2_a, alu_result_a, rsp_result_a;
  logic [3:0]  alu_ctl_a;
  logic [CNTW_A-1:0] op_count_a;
  // Instance B signals
  logic        req_ready_b, rsp_valid_b, rsp_zero_b, rsp_neg_b, rsp_err_b;
  logic        alu_zero_b, alu_neg_b;
  logic [31:0] alu_op1_b, alu_op2_b, alu_result_b, rsp_result_b;
  logic [3:0]  alu_ctl_b;
  logic [CNTW_B-1:0] op_count_b;

  // Currently selected instance view
  logic        cur_req_ready, cur_rsp_valid, cur_rsp_zero, cur_rsp_neg, cur_rsp_err;
  logic [31:0] cur_alu_op1, cur_alu_op2, cur_rsp_result;
  logic [3:0]  cur_alu_ctl;
  logic [15:0] cur_count;

  int compared = 0;
  int mismatched = 0;

  // Reference state per instance: completed legal ops and last legal request
  int          exp_count [2];
  logic [31:0] last_op1 [2];
  logic [31:0] last_op2 [2];
  logic [3:0]  last_ctl [2];
  int          exec_of [2];
  int          count_mod [2];

  always #5 clk = ~clk;

  // Behavioural ALU: plain arithmetic on the control code
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0110: return a - b;
      4'b1000: return a << b[4:0];
      4'b1001: return a >> b[4:0];
      4'b1010: return 32'($signed(a) >>> b[4:0]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic code_legal(input logic [3:0] c);
    return c inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h8, 4'h9, 4'hA};
  endfunction

  assign alu_result_a = alu_ref(alu_op1_a, alu_op2_a, alu_ctl_a);
  assign alu_zero_a   = (alu_result_a == 32'd0);
  assign alu_neg_a    = alu_result_a[31];
  assign alu_result_b = alu_ref(alu_op1_b, alu_op2_b, alu_ctl_b);
  assign alu_zero_b   = (alu_result_b == 32'd0);
  assign alu_neg_b    = alu_result_b[31];

  assign cur_req_ready  = sel ? req_ready_b  : req_ready_a;
  assign cur_rsp_valid  = sel ? rsp_valid_b  : rsp_valid_a;
  assign cur_rsp_zero   = sel ? rsp_zero_b   : rsp_zero_a;
  assign cur_rsp_neg    = sel ? rsp_neg_b    : rsp_neg_a;
  assign cur_rsp_err    = sel ? rsp_err_b    : rsp_err_a;
  assign cur_rsp_result = sel ? rsp_result_b : rsp_result_a;
  assign cur_alu_op1    = sel ? alu_op1_b    : alu_op1_a;
  assign cur_alu_op2    = sel ? alu_op2_b    : alu_op2_a;
  assign cur_alu_ctl    = sel ? alu_ctl_b    : alu_ctl_a;
  assign cur_count      = sel ? op_count_b   : {14'd0, op_count_a};

  alu_sequencer #(.DATA_W(32), .EXEC_CYCLES(EXEC_A), .CNT_W(CNTW_A)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid & ~sel), .o_req_ready(req_ready_a),
    .i_req_op1(req_op1), .i_req_op2(req_op2), .i_req_ctl(req_ctl),
    .o_alu_operand1(alu_op1_a), .o_alu_operand2(alu_op2_a), .o_alu_control(alu_ctl_a),
    .i_alu_result(alu_result_a), .i_alu_zero(alu_zero_a), .i_alu_neg(alu_neg_a),
    .o_rsp_valid(rsp_valid_a), .i_rsp_ready(rsp_ready & ~sel),
    .o_rsp_result(rsp_result_a), .o_rsp_zero(rsp_zero_a), .o_rsp_neg(rsp_neg_a),
    .o_rsp_err(rsp_err_a), .o_op_count(op_count_a)
  );

  alu_sequencer #(.DATA_W(32), .EXEC_CYCLES(EXEC_B), .CNT_W(CNTW_B)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid & sel), .o_req_ready(req_ready_b),
    .i_req_op1(req_op1), .i_req_op2(req_op2), .i_req_ctl(req_ctl),
    .o_alu_operand1(alu_op1_b), .o_alu_operand2(alu_op2_b), .o_alu_control(alu_ctl_b),
    .i_alu_result(alu_result_b), .i_alu_zero(alu_zero_b), .i_alu_neg(alu_neg_b),
    .o_rsp_valid(rsp_valid_b), .i_rsp_ready(rsp_ready & sel),
    .o_rsp_result(rsp_result_b), .o_rsp_zero(rsp_zero_b), .o_rsp_neg(rsp_neg_b),
    .o_rsp_err(rsp_err_b), .o_op_count(op_count_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_count[i] = 0;
      last_op1[i]  = '0;
      last_op2[i]  = '0;
      last_ctl[i]  = '0;
    end
  endtask

  // One full transaction on the selected instance, checked against the model.
  // hold_req keeps i_req_valid high with junk data while the op is in flight.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                       input int stall, input logic hold_req);
    logic        legal;
    logic [31:0] er;
    logic        ez, en;
    int          lat, w, exp_lat;
    legal = code_legal(c);
    er = legal ? alu_ref(a, b, c) : 32'd0;
    ez = legal ? (er == 32'd0) : 1'b0;
    en = legal ? er[31] : 1'b0;
    exp_lat = legal ? exec_of[sel] : 1;

    w = 0;
    while (!cur_req_ready && w < 20) begin step(); w++; end
    compared++;
    if (cur_req_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL ready_wait got %b want 1", cur_req_ready);
    end

    req_valid = 1'b1; req_op1 = a; req_op2 = b; req_ctl = c;
    step();
    req_valid = hold_req;
    req_op1 = $urandom; req_op2 = $urandom; req_ctl = 4'($urandom);
    if (legal) begin
      last_op1[sel] = a; last_op2[sel] = b; last_ctl[sel] = c;
    end
    compared++;
    if ({cur_alu_op1, cur_alu_op2, cur_alu_ctl} !== {last_op1[sel], last_op2[sel], last_ctl[sel]}) begin
      mismatched++;
      $display("[TB] FAIL alu_drive got %h/%h/%h want %h/%h/%h", cur_alu_op1, cur_alu_op2,
               cur_alu_ctl, last_op1[sel], last_op2[sel], last_ctl[sel]);
    end

    lat = 0;
    do begin
      step();
      lat++;
      req_op1 = $urandom; req_op2 = $urandom; req_ctl = 4'($urandom);
    end while (!cur_rsp_valid && lat < 40);
    compared++;
    if (lat != exp_lat) begin
      mismatched++;
      $display("[TB] FAIL latency got %0d want %0d (ctl %h)", lat, exp_lat, c);
    end
    compared++;
    if ({cur_rsp_valid, cur_rsp_result, cur_rsp_zero, cur_rsp_neg, cur_rsp_err, cur_req_ready}
        !== {1'b1, er, ez, en, ~legal, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL response got v%b r%h z%b n%b e%b rdy%b want v1 r%h z%b n%b e%b rdy0",
               cur_rsp_valid, cur_rsp_result, cur_rsp_zero, cur_rsp_neg, cur_rsp_err,
               cur_req_ready, er, ez, en, ~legal);
    end

    for (int s = 0; s < stall; s++) begin
      step();
      req_op1 = $urandom; req_op2 = $urandom; req_ctl = 4'($urandom);
      compared++;
      if ({cur_rsp_valid, cur_rsp_result, cur_rsp_err, cur_req_ready, cur_alu_ctl}
          !== {1'b1, er, ~legal, 1'b0, last_ctl[sel]}) begin
        mismatched++;
        $display("[TB] FAIL stall_hold got v%b r%h e%b rdy%b ctl%h want v1 r%h e%b rdy0 ctl%h",
                 cur_rsp_valid, cur_rsp_result, cur_rsp_err, cur_req_ready, cur_alu_ctl,
                 er, ~legal, last_ctl[sel]);
      end
    end

    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    if (legal) exp_count[sel] = (exp_count[sel] + 1) % count_mod[sel];
    compared++;
    if ({cur_rsp_valid, cur_req_ready, cur_count} !== {1'b0, 1'b1, 16'(exp_count[sel])}) begin
      mismatched++;
      $display("[TB] FAIL handshake got v%b rdy%b cnt%0d want v0 rdy1 cnt%0d",
               cur_rsp_valid, cur_req_ready, cur_count, exp_count[sel]);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      compared++;
      if ({cur_req_ready, cur_rsp_valid, cur_count, cur_alu_op1, cur_alu_op2, cur_alu_ctl,
           cur_rsp_result, cur_rsp_err} !== {1'b1, 1'b0, 16'd0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL reset_state sel%0d rdy%b v%b cnt%0d alu %h/%h/%h r%h e%b",
                 i, cur_req_ready, cur_rsp_valid, cur_count, cur_alu_op1, cur_alu_op2,
                 cur_alu_ctl, cur_rsp_result, cur_rsp_err);
      end
    end
  endtask

  task automatic test_and_fast();
    sel = 1'b1;
    do_op(32'hAAAA_AAAA, 32'h5555_5555, 4'b0000, 0, 1'b0);
    compared++;
    if ({cur_rsp_result, cur_rsp_zero, cur_count} !== {32'd0, 1'b1, 16'd1}) begin
      mismatched++;
      $display("[TB] FAIL and_fast got r%h z%b cnt%0d want r00000000 z1 cnt1",
               cur_rsp_result, cur_rsp_zero, cur_count);
    end
  endtask

  task automatic test_sub_sra_stall();
    sel = 1'b0;
    do_op(32'd20, 32'd10, 4'b0110, 4, 1'b0);
    do_op(-32'sd16, 32'd1, 4'b1010, 0, 1'b0);
    compared++;
    if ({cur_rsp_result, cur_rsp_neg, cur_count} !== {32'hFFFF_FFF8, 1'b1, 16'd2}) begin
      mismatched++;
      $display("[TB] FAIL sra_result got r%h n%b cnt%0d want rfffffff8 n1 cnt2",
               cur_rsp_result, cur_rsp_neg, cur_count);
    end
  endtask

  task automatic test_illegal();
    sel = 1'b0;
    do_op(32'd7, 32'd3, 4'b0101, 2, 1'b0);
    compared++;
    if ({cur_rsp_err, cur_rsp_result, cur_alu_ctl, cur_count} !== {1'b1, 32'd0, 4'b1010, 16'd2}) begin
      mismatched++;
      $display("[TB] FAIL illegal got e%b r%h ctl%h cnt%0d want e1 r0 ctlA cnt2",
               cur_rsp_err, cur_rsp_result, cur_alu_ctl, cur_count);
    end
  endtask

  task automatic test_wrap();
    int seq [5] = '{1, 2, 3, 0, 1};
    do_reset();
    sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_op(32'd10, 32'd20, 4'b0010, 0, 1'b0);
      compared++;
      if ({cur_rsp_result, cur_count} !== {32'd30, 16'(seq[i])}) begin
        mismatched++;
        $display("[TB] FAIL wrap_%0d got r%0d cnt%0d want r30 cnt%0d", i, cur_rsp_result,
                 cur_count, seq[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    sel = 1'b0;
    req_valid = 1'b1; req_op1 = 32'd1; req_op2 = 32'd4; req_ctl = 4'b1000;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    rsp_ready = 1'b1;
    step();
    rst = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_count[i] = 0; last_op1[i] = '0; last_op2[i] = '0; last_ctl[i] = '0;
    end
    compared++;
    if ({cur_rsp_valid, cur_req_ready, cur_count, cur_alu_ctl, cur_alu_op1}
        !== {1'b0, 1'b1, 16'd0, 4'd0, 32'd0}) begin
      mismatched++;
      $display("[TB] FAIL mid_reset got v%b rdy%b cnt%0d ctl%h op1%h want v0 rdy1 cnt0 ctl0 op10",
               cur_rsp_valid, cur_req_ready, cur_count, cur_alu_ctl, cur_alu_op1);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      compared++;
      if (cur_rsp_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL dropped_op_%0d got v%b want v0", i, cur_rsp_valid);
      end
    end
    do_op(32'h0000_8000, 32'd4, 4'b1001, 1, 1'b0);
    compared++;
    if ({cur_rsp_result, cur_count} !== {32'h0000_0800, 16'd1}) begin
      mismatched++;
      $display("[TB] FAIL shr_after_reset got r%h cnt%0d want r00000800 cnt1",
               cur_rsp_result, cur_count);
    end
  endtask

  task automatic test_random();
    logic [3:0] codes [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h8, 4'h9, 4'hA,
                               4'h5, 4'hF, 4'h7};
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom_range(0, 1));
      do_op($urandom, $urandom, codes[$urandom_range(0, 10)], $urandom_range(0, 3),
            1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    exec_of[0] = EXEC_A; exec_of[1] = EXEC_B;
    count_mod[0] = 1 << CNTW_A; count_mod[1] = 1 << CNTW_B;
    test_reset();
    test_and_fast();
    test_sub_sra_stall();
    test_illegal();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
